// File: rtl/core_pkg.sv
// Shared core definitions: datapath width, PC-source codes, NOP encoding and
// the fetch FSM state type. Build option: MISALIGN_TRAP_EN adds the FAULT state.
package core_pkg;

    localparam int XLEN_DEF = 32;

    localparam logic [1:0] PCSRC_SEQ  = 2'b00;
    localparam logic [1:0] PCSRC_JAL  = 2'b01;
    localparam logic [1:0] PCSRC_JALR = 2'b10;

    // ADDI x0, x0, 0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        ISSUE = 2'd2
`ifdef MISALIGN_TRAP_EN
        ,
        FAULT = 2'd3
`endif
    } fetch_state_t;

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC selection: JALR, JAL, taken branch, then sequential.
// All arithmetic wraps at XLEN bits.
module next_pc_calc
    import core_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic [XLEN-1:0] pc,
    input  logic [1:0]      pcsrc,
    input  logic            branch,
    input  logic            zero,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] rs1_val,
    output logic [XLEN-1:0] next_pc
);

    logic [XLEN-1:0] jalr_sum;
    logic [XLEN-1:0] pc_rel;
    logic [XLEN-1:0] pc_seq;

    assign jalr_sum = rs1_val + imm;
    assign pc_rel   = pc + imm;
    assign pc_seq   = pc + XLEN'(4);

    // Priority mux; the reserved pcsrc code falls through to branch/sequential.
    always_comb begin
        next_pc = pc_seq;
        if (pcsrc == PCSRC_JALR) begin
            next_pc = jalr_sum & ~XLEN'(1);
        end else if (pcsrc == PCSRC_JAL) begin
            next_pc = pc_rel;
        end else if (branch && zero) begin
            next_pc = pc_rel;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// RV32I instruction fetch and PC sequencing. Owns the PC, fetches over a
// req/ack handshake, holds the instruction for the control unit and loads the
// next PC when the datapath signals completion.
// Build option: MISALIGN_TRAP_EN traps misaligned targets into FAULT
// (adds the fetch_fault port); otherwise target bits [1:0] are cleared.
//
// state | meaning
// IDLE  | one cycle after reset before the first fetch
// FETCH | imem_req high at pc, waiting for imem_ack
// ISSUE | instr valid for execution, waiting for advance
// FAULT | misaligned target seen, parked until reset (MISALIGN_TRAP_EN only)
module fetch_unit
    import core_pkg::*;
#(
    parameter int              XLEN     = XLEN_DEF,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    output logic             imem_req,
    output logic [XLEN-1:0]  imem_addr,
    input  logic             imem_ack,
    input  logic [31:0]      imem_rdata,
    output logic [31:0]      instr,
    output logic [6:0]       opcode,
    output logic [2:0]       func3,
    output logic [6:0]       func7,
    output logic             instr_valid,
    output logic [XLEN-1:0]  pc,
    output logic [XLEN-1:0]  pc_plus4,
    input  logic             advance,
    input  logic [1:0]       pcsrc,
    input  logic             branch,
    input  logic             zero,
    input  logic [XLEN-1:0]  imm,
    input  logic [XLEN-1:0]  rs1_val,
    output logic [CNT_W-1:0] instret
`ifdef MISALIGN_TRAP_EN
    ,
    output logic             fetch_fault
`endif
);

    fetch_state_t    state;
    fetch_state_t    state_nx;
    logic [XLEN-1:0] next_pc;
    logic [XLEN-1:0] pc_load;
    logic            ld_instr;
    logic            ld_pc;

    next_pc_calc #(.XLEN(XLEN)) u_next_pc_calc (
        .pc      (pc),
        .pcsrc   (pcsrc),
        .branch  (branch),
        .zero    (zero),
        .imm     (imm),
        .rs1_val (rs1_val),
        .next_pc (next_pc)
    );

`ifdef MISALIGN_TRAP_EN
    logic misaligned;
    logic fault;

    assign misaligned  = |next_pc[1:0];
    assign pc_load     = next_pc;
    assign fetch_fault = fault;
`else
    assign pc_load = next_pc & ~XLEN'(3);
`endif

    assign imem_addr = pc;
    assign pc_plus4  = pc + XLEN'(4);
    assign opcode    = instr[6:0];
    assign func3     = instr[14:12];
    assign func7     = instr[31:25];

    // Next-state decode and handshake outputs; ack and advance only matter in their own state.
    always_comb begin
        state_nx    = state;
        ld_instr    = 1'b0;
        ld_pc       = 1'b0;
        imem_req    = 1'b0;
        instr_valid = 1'b0;
`ifdef MISALIGN_TRAP_EN
        fault       = 1'b0;
`endif
        case (state)
            IDLE: begin
                state_nx = FETCH;
            end
            FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    ld_instr = 1'b1;
                    state_nx = ISSUE;
                end
            end
            ISSUE: begin
                instr_valid = 1'b1;
                if (advance) begin
`ifdef MISALIGN_TRAP_EN
                    if (misaligned) begin
                        state_nx = FAULT;
                    end else begin
                        ld_pc    = 1'b1;
                        state_nx = FETCH;
                    end
`else
                    ld_pc    = 1'b1;
                    state_nx = FETCH;
`endif
                end
            end
`ifdef MISALIGN_TRAP_EN
            FAULT: begin
                fault = 1'b1;
            end
`endif
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // State, PC, held instruction and retire counter; reset overrides every load.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            pc      <= RESET_PC;
            instr   <= NOP_INSTR;
            instret <= '0;
        end else begin
            state <= state_nx;
            if (ld_instr) begin
                instr <= imem_rdata;
            end
            if (ld_pc) begin
                pc      <= pc_load;
                instret <= instret + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: reset, sequential/branch/JAL/JALR sequencing,
// PC wrap, wait states, mid-fetch reset and the misaligned-target behaviour.
module tb_fetch_unit;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [6:0]  opcode;
    logic [2:0]  func3;
    logic [6:0]  func7;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        advance;
    logic [1:0]  pcsrc;
    logic        branch;
    logic        zero;
    logic [31:0] imm;
    logic [31:0] rs1_val;
    logic [31:0] instret;
`ifdef MISALIGN_TRAP_EN
    logic        fetch_fault;
`endif

    logic        rdata_override;
    logic [31:0] rdata_force;
    logic [31:0] exp_pc;
    logic [31:0] exp_ret;
    int          tests;
    int          fails;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h0001_0003) ^ 32'hC0DE_0013;
    endfunction

    assign imem_rdata = rdata_override ? rdata_force : mem_word(imem_addr);

    fetch_unit #(.XLEN(32), .RESET_PC(32'h0), .CNT_W(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .instr       (instr),
        .opcode      (opcode),
        .func3       (func3),
        .func7       (func7),
        .instr_valid (instr_valid),
        .pc          (pc),
        .pc_plus4    (pc_plus4),
        .advance     (advance),
        .pcsrc       (pcsrc),
        .branch      (branch),
        .zero        (zero),
        .imm         (imm),
        .rs1_val     (rs1_val),
        .instret     (instret)
`ifdef MISALIGN_TRAP_EN
        ,
        .fetch_fault (fetch_fault)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_issue(input string tag);
        logic [31:0] w;
        w = mem_word(exp_pc);
        check({tag, "_valid"}, instr_valid, 1'b1);
        check({tag, "_req"}, imem_req, 1'b0);
        check({tag, "_instr"}, instr, w);
        check({tag, "_opcode"}, opcode, w[6:0]);
        check({tag, "_func3"}, func3, w[14:12]);
        check({tag, "_func7"}, func7, w[31:25]);
    endtask

    // Called at a negedge in ISSUE with ack tied high; returns at the next ISSUE.
    task automatic step_adv(input string tag, input logic [1:0] ps, input logic br,
                            input logic zr, input logic [31:0] im, input logic [31:0] r1,
                            input logic [31:0] exp_next);
        logic [31:0] p4;
        p4 = exp_pc + 32'd4;
        check({tag, "_pc_plus4"}, pc_plus4, p4);
        pcsrc   = ps;
        branch  = br;
        zero    = zr;
        imm     = im;
        rs1_val = r1;
        advance = 1'b1;
        @(negedge clk);
        advance = 1'b0;
        pcsrc   = 2'b00;
        branch  = 1'b0;
        zero    = 1'b0;
        exp_pc  = exp_next;
        exp_ret = exp_ret + 32'd1;
        check({tag, "_fetch_req"}, imem_req, 1'b1);
        check({tag, "_fetch_addr"}, imem_addr, exp_pc);
        check({tag, "_fetch_valid"}, instr_valid, 1'b0);
        check({tag, "_pc"}, pc, exp_pc);
        check({tag, "_instret"}, instret, exp_ret);
        @(negedge clk);
        check_issue(tag);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst = 1'b1;
        imem_ack = 1'b1;
        advance = 1'b0;
        pcsrc = 2'b00;
        branch = 1'b0;
        zero = 1'b0;
        imm = 32'h0;
        rs1_val = 32'h0;
        rdata_override = 1'b0;
        rdata_force = 32'h0;
        exp_pc = 32'h0;
        exp_ret = 32'h0;

        // Reset, first fetch with a zero-wait memory
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_pc", pc, 32'h0);
        check("rst_instr", instr, 32'h0000_0013);
        check("rst_instret", instret, 32'h0);
        check("rst_req", imem_req, 1'b0);
        check("rst_valid", instr_valid, 1'b0);
`ifdef MISALIGN_TRAP_EN
        check("rst_fault", fetch_fault, 1'b0);
`endif
        @(negedge clk);
        check("first_req", imem_req, 1'b1);
        check("first_addr", imem_addr, 32'h0);
        check("first_valid", instr_valid, 1'b0);
        @(negedge clk);
        check_issue("first");

        // Sequential, branch, reserved pcsrc, JAL, JALR, wrap
        step_adv("seq0", 2'b00, 1'b0, 1'b0, 32'h0, 32'h0, 32'h4);
        step_adv("seq1", 2'b00, 1'b0, 1'b1, 32'h40, 32'h0, 32'h8);
        step_adv("seq2", 2'b00, 1'b0, 1'b0, 32'h0, 32'h0, 32'hC);
        check("seq_instret3", instret, 32'd3);
        step_adv("br_c", 2'b00, 1'b1, 1'b1, 32'hFFFF_FFFC, 32'h0, 32'h8);
        step_adv("br_nt", 2'b00, 1'b1, 1'b0, 32'hFFFF_FFF8, 32'h0, 32'hC);
        step_adv("br_c2", 2'b00, 1'b1, 1'b1, 32'hFFFF_FFFC, 32'h0, 32'h8);
        step_adv("br_t", 2'b00, 1'b1, 1'b1, 32'hFFFF_FFF8, 32'h0, 32'h0);
        step_adv("rsvd", 2'b11, 1'b0, 1'b0, 32'h100, 32'h200, 32'h4);
        step_adv("jal0", 2'b01, 1'b0, 1'b0, 32'hC, 32'h0, 32'h10);
        step_adv("jal1", 2'b01, 1'b0, 1'b0, 32'h20, 32'h999, 32'h30);
        step_adv("jalr", 2'b10, 1'b1, 1'b1, 32'h4, 32'h101, 32'h104);
        step_adv("jalr_hi", 2'b10, 1'b0, 1'b0, 32'hC, 32'hFFFF_FFF0, 32'hFFFF_FFFC);
        step_adv("wrap", 2'b00, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);

        // ack while in ISSUE must not reload instr
        rdata_override = 1'b1;
        rdata_force = 32'hDEAD_BEEF;
        @(negedge clk);
        check("ack_in_issue_instr", instr, mem_word(32'h0));
        rdata_override = 1'b0;

        // Misaligned JAL target
`ifdef MISALIGN_TRAP_EN
        pcsrc = 2'b01;
        imm = 32'h2;
        advance = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check("mis_fault", fetch_fault, 1'b1);
            check("mis_req", imem_req, 1'b0);
            check("mis_valid", instr_valid, 1'b0);
            check("mis_pc", pc, exp_pc);
            check("mis_instret", instret, exp_ret);
            @(negedge clk);
        end
        advance = 1'b0;
        pcsrc = 2'b00;
`else
        step_adv("mis", 2'b01, 1'b0, 1'b0, 32'h2, 32'h0, 32'h0);
`endif

        // Wait states with an advance pulsed during FETCH
        rst = 1'b1;
        imem_ack = 1'b0;
        @(negedge clk);
`ifdef MISALIGN_TRAP_EN
        check("fault_cleared", fetch_fault, 1'b0);
`endif
        rst = 1'b0;
        exp_pc = 32'h0;
        exp_ret = 32'h0;
        @(negedge clk);
        pcsrc = 2'b01;
        imm = 32'h40;
        for (int i = 0; i < 3; i++) begin
            advance = (i == 1);
            check("ws_req", imem_req, 1'b1);
            check("ws_addr", imem_addr, 32'h0);
            check("ws_valid", instr_valid, 1'b0);
            @(negedge clk);
        end
        advance = 1'b0;
        pcsrc = 2'b00;
        check("ws_req4", imem_req, 1'b1);
        check("ws_addr4", imem_addr, 32'h0);
        check("ws_pc", pc, 32'h0);
        check("ws_instret", instret, 32'h0);
        imem_ack = 1'b1;
        @(negedge clk);
        check_issue("ws");

        // Reset during the second wait cycle of a fetch, with ack and advance also high
        imem_ack = 1'b0;
        advance = 1'b1;
        @(negedge clk);
        advance = 1'b0;
        check("mid_req", imem_req, 1'b1);
        check("mid_addr", imem_addr, 32'h4);
        @(negedge clk);
        rst = 1'b1;
        imem_ack = 1'b1;
        advance = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        advance = 1'b0;
        check("mid_rst_req", imem_req, 1'b0);
        check("mid_rst_valid", instr_valid, 1'b0);
        check("mid_rst_pc", pc, 32'h0);
        check("mid_rst_instret", instret, 32'h0);
        check("mid_rst_instr", instr, 32'h0000_0013);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch and PC-sequencing stage for the RV32I core.
- Sits directly upstream of the control unit and owns the PC register.
- Fetches from instruction memory with a req/ack handshake and presents the held instruction and its decoded fields (opcode, func3, func7) to the control unit.
- Computes the next PC from the control unit's pcsrc/branch outputs plus datapath zero, imm and rs1 when the datapath signals that the instruction is complete.

Parameters:
- XLEN, 32, datapath/address width.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- imem_req  out  1  fetch request, held until acked.
- imem_addr  out  XLEN  fetch address (= pc).
- imem_ack  in  1  memory has placed the instruction on imem_rdata this cycle.
- imem_rdata  in  32  instruction word.
- instr  out  32  held instruction.
- opcode  out  7  instr[6:0].
- func3  out  3  instr[14:12].
- func7  out  7  instr[31:25].
- instr_valid  out  1  instr/fields are valid for execution.
- pc  out  XLEN  PC of the held instruction.
- pc_plus4  out  XLEN  pc+4, the JAL/JALR link value.
- advance  in  1  datapath has completed the instruction; load next PC.
- pcsrc  in  2  from control unit: 00 sequential, 01 JAL, 10 JALR, 11 reserved.
- branch  in  1  from control unit (BEQ).
- zero  in  1  ALU zero flag.
- imm  in  XLEN  sign-extended immediate.
- rs1_val  in  XLEN  rs1 operand, used for JALR.
- instret  out  CNT_W  retired-instruction count.
- fetch_fault  out  1  misaligned target trap; exists only with MISALIGN_TRAP_EN.

Behaviour:
- FSM states: IDLE, FETCH, ISSUE, plus FAULT when MISALIGN_TRAP_EN is defined.
- Reset (rst=1 at a clock edge):
  - state=IDLE, pc=RESET_PC, instr=32'h0000_0013 (NOP), instret=0.
  - imem_req=0, instr_valid=0, fetch_fault=0.
  - Reset wins over every simultaneous event, including ack and advance. Asserting reset mid-fetch abandons the request.
- IDLE: unconditionally moves to FETCH on the next cycle, so imem_req rises in the 2nd cycle after rst deasserts.
- FETCH:
  - imem_req=1; imem_addr=pc, stable until acked.
  - On imem_ack=1: instr<=imem_rdata, go to ISSUE.
  - Otherwise stay in FETCH; there is no timeout.
  - With a zero-wait memory (ack in the first req cycle), instr_valid is asserted the following cycle.
- ISSUE:
  - instr_valid=1; instr and pc are held stable.
  - advance=0: stay in ISSUE.
  - advance=1: pc<=next_pc, instret<=instret+1, go to FETCH.
  - advance is ignored in every other state. imem_ack is ignored outside FETCH.
- next_pc (combinational, XLEN-bit wrap-around arithmetic), in priority order:
  1. pcsrc==10: (rs1_val+imm) & ~1.
  2. pcsrc==01: pc+imm.
  3. branch & zero: pc+imm.
  4. Otherwise, including pcsrc==11: pc+4.
- Throughput: minimum 2 cycles per instruction (FETCH→ISSUE).
- PC wrap: pc=32'hFFFF_FFFC sequential gives 0.
- instret wraps from all-ones to 0 silently.
- Field outputs (opcode, func3, func7) are combinational slices of instr. pc_plus4 = pc+4.

Optional Feature:
MISALIGN_TRAP_EN
- Defined:
  - In ISSUE, advance with next_pc[1:0]!=0 moves to FAULT instead of FETCH.
  - pc is not updated and instret is not incremented.
  - In FAULT: fetch_fault=1, instr_valid=0, imem_req=0. FAULT is exited only by rst.
- Not defined:
  - The fetch_fault port and the FAULT state do not exist.
  - next_pc bits [1:0] are forced to 0 before loading pc.

Decomposition:
- Shared package core_pkg holds:
  - XLEN_DEF;
  - the PCSRC_SEQ/PCSRC_JAL/PCSRC_JALR codes;
  - the NOP encoding 32'h0000_0013;
  - the fetch FSM state enum.
- The control unit also uses the pcsrc codes from core_pkg.
- One sub-module: next_pc_calc, a purely combinational next_pc computation (adders and priority mux). It is reused for verification checking.

Test Plan:
1. Reset with RESET_PC=0, imem_ack tied 1 → imem_req high in the 2nd cycle after rst falls, imem_addr=0; instr_valid high the next cycle with instr=imem_rdata.
2. Sequential: three advances with pcsrc=00, branch=0 → pc 0→4→8→C, instret=3.
3. Branch with pc=8, imm=-8: branch=1, zero=1 → pc=0. Same stimulus with zero=0 → pc=C.
4. JALR with pcsrc=10, rs1_val=32'h101, imm=4 → pc=32'h104, pc_plus4 held at old pc+4 before advance. JAL with pc=0x10, imm=0x20 → pc=0x30.
5. Wait states: ack delayed 3 cycles → imem_req and imem_addr stable for 4 cycles, instr_valid=0 throughout. Also: rst in the 2nd wait cycle → IDLE, pc=RESET_PC; an advance pulsed during FETCH has no effect.
6. MISALIGN_TRAP_EN defined: JAL with imm=2 → fetch_fault=1, pc unchanged, instret unchanged, imem_req=0 until rst. Macro undefined: same stimulus → pc=old pc+0 (target bits [1:0] cleared).
